pwm_generator: RTL and testbench

- Registered PWM waveform generator, driven by an externally supplied free-running counter value.
- Sits downstream of the timer/counter block and upstream of the output pin mux.
- Supports three modes: left-aligned, right-aligned, and unaligned (two-compare) PWM.
- Output edges are placed by equality matches of count_val against 0, compare1 and compare2.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_generator.sv | 68 ++++++
 tb/tb_pwm_generator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: counter width and functions-field mode decode.
package pwm_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned FUNC_ALIGN_BIT = 1;
  localparam int unsigned FUNC_RIGHT_BIT = 0;

  localparam logic [1:0] MODE_LEFT      = 2'b00;
  localparam logic [1:0] MODE_RIGHT     = 2'b01;
  localparam logic [1:0] MODE_UNALIGNED = 2'b10;

  // The unaligned bit wins, so the right/left bit is a don't-care in unaligned mode.
  function automatic logic [1:0] decode_mode(input logic align_bit, input logic right_bit);
    if (align_bit) begin
      return MODE_UNALIGNED;
    end else if (right_bit) begin
      return MODE_RIGHT;
    end else begin
      return MODE_LEFT;
    end
  endfunction

endpackage

// File: rtl/pwm_generator.sv
// Registered PWM output whose edges are placed by equality matches of an external count
// against zero, compare1 and compare2.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = pwm_pkg::CNT_W,
  parameter int unsigned FUNC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_en,
  input  logic [CNT_W-1:0]  period,
  input  logic [FUNC_W-1:0] functions,
  input  logic [CNT_W-1:0]  compare1,
  input  logic [CNT_W-1:0]  compare2,
  input  logic [CNT_W-1:0]  count_val,
  output logic              pwm_out
);

  logic       pwm_q, pwm_d;
  logic [1:0] mode;
  logic       zero_hit, cmp1_hit, cmp2_hit;

  // period and the upper function bits are informational only.
  logic unused_inputs;
  assign unused_inputs = ^{period, functions[FUNC_W-1:2]};

  assign mode     = decode_mode(functions[FUNC_ALIGN_BIT], functions[FUNC_RIGHT_BIT]);
  assign zero_hit = (count_val == '0);
  assign cmp1_hit = (count_val == compare1);
  assign cmp2_hit = (count_val == compare2);

  always_comb begin
    pwm_d = pwm_q;
    if (!pwm_en) begin
      pwm_d = 1'b0;
    end else begin
      case (mode)
        MODE_LEFT: begin
          if (cmp1_hit)      pwm_d = 1'b0;
          else if (zero_hit) pwm_d = 1'b1;
        end
        MODE_RIGHT: begin
          if (cmp1_hit)      pwm_d = 1'b1;
          else if (zero_hit) pwm_d = 1'b0;
        end
        default: begin
          // compare2 beats compare1, so equal compares never produce a pulse.
          if (cmp2_hit)      pwm_d = 1'b0;
          else if (cmp1_hit) pwm_d = 1'b1;
          else if (zero_hit) pwm_d = 1'b0;
        end
      endcase
    end
  end

  // Reset is active-high despite the port name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed self-checking bench for pwm_generator with hand-computed expected outputs.
module tb_pwm_generator;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FUNC_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pwm_en;
  logic [CNT_W-1:0]  period;
  logic [FUNC_W-1:0] functions;
  logic [CNT_W-1:0]  compare1;
  logic [CNT_W-1:0]  compare2;
  logic [CNT_W-1:0]  count_val;
  logic              pwm_out;

  int n_vec = 0;
  int n_err = 0;

  pwm_generator #(
    .CNT_W  (CNT_W),
    .FUNC_W (FUNC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_en    (pwm_en),
    .period    (period),
    .functions (functions),
    .compare1  (compare1),
    .compare2  (compare2),
    .count_val (count_val),
    .pwm_out   (pwm_out)
  );

  always #5 clk = ~clk;

  // Apply one count value, clock it in, then compare the registered output.
  task automatic step(input string tag, input int unsigned cnt, input logic exp);
    count_val = CNT_W'(cnt);
    @(posedge clk);
    #1;
    n_vec++;
    assert (pwm_out === exp)
    else begin
      n_err++;
      $error("FAIL %s: count=%0d observed %b expected %b", tag, cnt, pwm_out, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    pwm_en    = 1'b1;
    period    = 16'd10;
    functions = 8'h00;
    compare1  = 16'd3;
    compare2  = 16'd6;
    count_val = '0;

    // Reset held with a would-be-setting count: output must stay low.
    step("rst0", 0, 1'b0);
    step("rst1", 0, 1'b0);

    rst_n  = 1'b0;
    pwm_en = 1'b0;
    step("dis0", 0, 1'b0);
    step("dis3", 3, 1'b0);

    // Left-aligned
    pwm_en    = 1'b1;
    functions = 8'h00;
    compare1  = 16'd3;
    step("left0", 0, 1'b1);
    step("left1", 1, 1'b1);
    step("left2", 2, 1'b1);
    step("left3", 3, 1'b0);
    step("left8", 8, 1'b0);
    step("left0b", 0, 1'b1);

    // Right-aligned, entering with output high
    functions = 8'h01;
    step("right1", 1, 1'b1);
    step("right0", 0, 1'b0);
    step("right3", 3, 1'b1);
    step("right8", 8, 1'b1);
    step("right0b", 0, 1'b0);

    // Unaligned
    functions = 8'h02;
    compare1  = 16'd3;
    compare2  = 16'd6;
    step("un1", 1, 1'b0);
    step("un0", 0, 1'b0);
    step("un1b", 1, 1'b0);
    step("un2", 2, 1'b0);
    step("un3", 3, 1'b1);
    step("un4", 4, 1'b1);
    step("un5", 5, 1'b1);
    step("un6", 6, 1'b0);
    step("un7", 7, 1'b0);
    step("un8", 8, 1'b0);
    step("un0b", 0, 1'b0);
    step("un3b", 3, 1'b1);
    step("un6b", 6, 1'b0);

    // Boundary: left with compare1 = 0 is 0% duty
    functions = 8'h00;
    compare1  = 16'd0;
    for (int i = 0; i < 8; i++) step("left_c0", i, 1'b0);

    // Boundary: right with compare1 = 0 is constant high
    functions = 8'h01;
    for (int i = 0; i < 8; i++) step("right_c0", i, 1'b1);

    // Boundary: unaligned with equal compares never pulses
    functions = 8'h02;
    compare1  = 16'd4;
    compare2  = 16'd4;
    for (int i = 0; i < 8; i++) step("un_eq", i, 1'b0);

    // Upper function bits ignored; bit0 ignored in unaligned mode
    functions = 8'hFD;
    compare1  = 16'd3;
    step("fhi_r0", 0, 1'b0);
    step("fhi_r3", 3, 1'b1);
    functions = 8'h03;
    compare1  = 16'd2;
    compare2  = 16'd4;
    step("f3_0", 0, 1'b0);
    step("f3_2", 2, 1'b1);
    step("f3_4", 4, 1'b0);

    // Enable dropped mid-pulse; no state survives re-enable
    functions = 8'h00;
    compare1  = 16'd5;
    step("en_0", 0, 1'b1);
    step("en_1", 1, 1'b1);
    pwm_en = 1'b0;
    step("en_off", 2, 1'b0);
    pwm_en = 1'b1;
    step("en_back", 3, 1'b0);

    // Reset pulsed mid-pulse; resumes at next zero
    step("rp_0", 0, 1'b1);
    step("rp_1", 1, 1'b1);
    rst_n = 1'b1;
    step("rp_rst", 2, 1'b0);
    rst_n = 1'b0;
    step("rp_3", 3, 1'b0);
    step("rp_4", 4, 1'b0);
    step("rp_0b", 0, 1'b1);
    step("rp_5", 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
